onehot_regfile_param: RTL and testbench
=======================================

Name: onehot_regfile_param

Overview:
- Parametrised successor to the fixed 32x32 one-hot-select register file.
- It has one write port and two read ports, addressed by one-hot select vectors Dselect, Aselect and Bselect. Register 0 can be configured to read as zero.
- New capabilities: configurable width and depth, an explicit write enable, an asynchronous clear, and a sticky detector for illegal (non-one-hot) selects.
- Sits between decode (which produces the selects) and the ALU operand buses abus/bbus; dbus carries the writeback data.

Parameters:
- WIDTH, 32, data width of each register and of dbus/abus/bbus.
- DEPTH, 32, number of registers; also the width of each select vector (2..64).
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded; when 0 it is an ordinary register.

Ports:
- clk  in  1  clock; register writes occur on the falling edge.
- reset_n  in  1  asynchronous, active-low reset.
- Dselect  in  DEPTH  one-hot write select.
- wr_en  in  1  write enable, sampled on the falling edge of clk.
- dbus  in  WIDTH  write data.
- Aselect  in  DEPTH  one-hot read select, port A.
- Bselect  in  DEPTH  one-hot read select, port B.
- abus  out  WIDTH  read data, port A.
- bbus  out  WIDTH  read data, port B.
- clr_err  in  1  synchronous clear of sel_err, sampled on the falling edge.
- sel_err  out  1  sticky flag: a non-one-hot select was presented.

Behaviour:
- Reset
  - reset_n=0 immediately clears all registers to 0 and clears sel_err to 0, independent of clk.
  - While reset is held, abus=bbus=0.
  - Deassertion takes effect at the next falling edge.
- Write
  - On the falling edge, with wr_en=1 and Dselect exactly one-hot at bit i, reg[i] <= dbus.
  - Write latency is one edge: data is visible on the read ports after that falling edge.
- Zero register: if ZERO_REG=1 and i=0, the write is discarded and no error is raised.
- Illegal write select
  - wr_en=1 with Dselect all-zero or multi-hot: no register changes, and sel_err <= 1 at that edge.
  - wr_en=0: Dselect is ignored and never flagged.
- Read
  - Purely combinational from the stored array: abus = reg[j] where Aselect is one-hot at bit j; bbus likewise from Bselect.
  - A and B may select the same register; both buses then carry the same value.
- Illegal read select
  - Aselect or Bselect all-zero or multi-hot drives that bus to 0.
  - sel_err <= 1 at the next falling edge if the illegal select is still present at that edge.
- sel_err
  - Sticky; cleared only by reset_n or by clr_err=1 at a falling edge.
  - Simultaneous clr_err and a new error at the same edge: the new error wins, so sel_err=1.
- Read during write, same register, bypass disabled: the bus shows the old value until the falling edge, then the new value.
- One-hot check: popcount==1, implemented as v!=0 && (v&(v-1))==0.

Optional Feature:
- Macro: ONEHOT_REGFILE_BYPASS_EN.
- When defined
  - If wr_en=1, Dselect is legal one-hot at bit i, and Aselect (or Bselect) equals Dselect, that bus combinationally returns dbus before the edge (write-through forwarding).
  - If ZERO_REG=1 and i=0, no bypass occurs; the bus stays 0.
- When undefined: the read ports return only stored values.
- The macro has no effect on sel_err or on write timing.

Test Plan:
- Reset then read: reset_n pulsed low, Aselect=32'h00001000, Bselect=32'h02000000 -> abus=0, bbus=0, sel_err=0.
- Write and readback: Dselect=32'h02000000, dbus=32'h76543210, wr_en=1, falling edge; then Aselect=32'h02000000, Bselect=32'h00000001 -> abus=32'h76543210, bbus=0.
- Zero register (ZERO_REG=1): Dselect=32'h00000001, dbus=32'h00001111, wr_en=1, falling edge -> Aselect=32'h00000001 gives abus=0; sel_err=0.
- Illegal write: first write 32'hF4820000 to bit 12. Then Dselect=32'h00001001, dbus=32'hFFFFFFFF, wr_en=1, falling edge:
  - Aselect=32'h00001000 -> abus=32'hF4820000 (unchanged).
  - Aselect=32'h00000001 -> abus=0.
  - sel_err=1, and it stays 1 until clr_err=1 at a falling edge, then returns to 0.
- Async reset mid-operation: after writing 32'h80876263 to bit 6, drop reset_n low while clk=1 -> Aselect=32'h00000040 gives abus=0 immediately, without waiting for an edge.
- Bypass (ONEHOT_REGFILE_BYPASS_EN defined): Dselect=Aselect=32'h00400000, dbus=32'hABCDEF90, wr_en=1, clk high.
  - abus=32'hABCDEF90 before the falling edge.
  - Without the macro, abus shows the old value (0) until the edge.

Source files
------------

// File: rtl/onehot_regfile_param.sv
// One-hot addressed register file: 1 write / 2 read ports, sticky select error.
// Optional write-through forwarding under ONEHOT_REGFILE_BYPASS_EN.
module onehot_regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DEPTH-1:0] Dselect,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] dbus,
    input  logic [DEPTH-1:0] Aselect,
    input  logic [DEPTH-1:0] Bselect,
    output logic [WIDTH-1:0] abus,
    output logic [WIDTH-1:0] bbus,
    input  logic             clr_err,
    output logic             sel_err
);

    localparam logic [DEPTH-1:0] ONE   = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] ZMASK = (ZERO_REG != 0) ? ONE : '0;

    function automatic logic onehot(input logic [DEPTH-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             sel_err_q;
    logic             sel_err_d;
    logic             d_ok;
    logic             a_ok;
    logic             b_ok;
    logic [DEPTH-1:0] wmask;
    logic [WIDTH-1:0] a_rd;
    logic [WIDTH-1:0] b_rd;

    assign d_ok = onehot(Dselect);
    assign a_ok = onehot(Aselect);
    assign b_ok = onehot(Bselect);

    // Register 0 is masked out of the write set when it is the zero register
    assign wmask = (wr_en && d_ok) ? (Dselect & ~ZMASK) : '0;

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wmask[i]) begin
                    mem_q[i] <= dbus;
                end
            end
        end
    end

    always_comb begin
        a_rd = '0;
        b_rd = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (Aselect[k]) a_rd = a_rd | mem_q[k];
            if (Bselect[k]) b_rd = b_rd | mem_q[k];
        end
        if (!a_ok) a_rd = '0;
        if (!b_ok) b_rd = '0;
    end

`ifdef ONEHOT_REGFILE_BYPASS_EN
    logic byp_ok;

    assign byp_ok = (wmask != '0);
    assign abus   = (byp_ok && (Aselect == Dselect)) ? dbus : a_rd;
    assign bbus   = (byp_ok && (Bselect == Dselect)) ? dbus : b_rd;
`else
    assign abus = a_rd;
    assign bbus = b_rd;
`endif

    // A fresh error outranks a simultaneous clear
    always_comb begin
        sel_err_d = sel_err_q;
        if (clr_err) sel_err_d = 1'b0;
        if ((wr_en && !d_ok) || !a_ok || !b_ok) sel_err_d = 1'b1;
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_onehot_regfile_param.sv
// Directed bench for onehot_regfile_param (default 32x32, ZERO_REG=1).
module tb_onehot_regfile_param;

    logic        clk;
    logic        reset_n;
    logic [31:0] Dselect;
    logic        wr_en;
    logic [31:0] dbus;
    logic [31:0] Aselect;
    logic [31:0] Bselect;
    logic [31:0] abus;
    logic [31:0] bbus;
    logic        clr_err;
    logic        sel_err;

    int n_total = 0;
    int n_pass  = 0;

    onehot_regfile_param #(
        .WIDTH(32),
        .DEPTH(32),
        .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .Dselect(Dselect),
        .wr_en(wr_en),
        .dbus(dbus),
        .Aselect(Aselect),
        .Bselect(Bselect),
        .abus(abus),
        .bbus(bbus),
        .clr_err(clr_err),
        .sel_err(sel_err)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fall();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] sel, input logic [31:0] data);
        Dselect = sel;
        dbus    = data;
        wr_en   = 1'b1;
        fall();
        wr_en   = 1'b0;
        Dselect = 32'h00000001;
    endtask

    logic [31:0] byp_exp;

    initial begin
        reset_n = 1'b0;
        Dselect = 32'h00000001;
        wr_en   = 1'b0;
        dbus    = '0;
        Aselect = 32'h00001000;
        Bselect = 32'h02000000;
        clr_err = 1'b0;
        fall();
        fall();
        chk("rst_abus", abus, 32'h0);
        chk("rst_bbus", bbus, 32'h0);
        chk("rst_err", {31'b0, sel_err}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fall();

        // write and readback
        wr(32'h02000000, 32'h76543210);
        Aselect = 32'h02000000;
        Bselect = 32'h00000001;
        #1;
        chk("wr_abus", abus, 32'h76543210);
        chk("wr_bbus0", bbus, 32'h0);
        Bselect = 32'h02000000;
        #1;
        chk("same_reg_b", bbus, 32'h76543210);
        Bselect = 32'h00000001;

        // zero register
        wr(32'h00000001, 32'h00001111);
        Aselect = 32'h00000001;
        #1;
        chk("zero_abus", abus, 32'h0);
        chk("zero_err", {31'b0, sel_err}, 32'h0);

        // illegal multi-hot write
        wr(32'h00001000, 32'hF4820000);
        wr(32'h00001001, 32'hFFFFFFFF);
        Aselect = 32'h00001000;
        #1;
        chk("illw_keep", abus, 32'hF4820000);
        Aselect = 32'h00000001;
        #1;
        chk("illw_r0", abus, 32'h0);
        chk("illw_err", {31'b0, sel_err}, 32'h1);
        fall();
        chk("err_sticky", {31'b0, sel_err}, 32'h1);
        clr_err = 1'b1;
        fall();
        clr_err = 1'b0;
        chk("err_clr", {31'b0, sel_err}, 32'h0);

        // illegal all-zero write select
        wr(32'h00000000, 32'h12345678);
        chk("zsel_err", {31'b0, sel_err}, 32'h1);
        clr_err = 1'b1;
        fall();
        clr_err = 1'b0;

        // wr_en low ignores a bad Dselect
        Dselect = 32'h0;
        fall();
        chk("noen_err", {31'b0, sel_err}, 32'h0);
        Dselect = 32'h00000001;

        // illegal read select
        Aselect = 32'h0;
        #1;
        chk("illr_abus", abus, 32'h0);
        chk("illr_pre", {31'b0, sel_err}, 32'h0);
        fall();
        chk("illr_err", {31'b0, sel_err}, 32'h1);
        Aselect = 32'h00001000;
        clr_err = 1'b1;
        fall();
        clr_err = 1'b0;
        chk("illr_clr", {31'b0, sel_err}, 32'h0);

        // multi-hot B bus with simultaneous clear: error wins
        Bselect = 32'h02001000;
        clr_err = 1'b1;
        #1;
        chk("mh_bbus", bbus, 32'h0);
        fall();
        chk("clr_vs_err", {31'b0, sel_err}, 32'h1);
        Bselect = 32'h00000001;
        fall();
        clr_err = 1'b0;
        chk("clr_after", {31'b0, sel_err}, 32'h0);

        // read during write, clk high
        @(posedge clk);
        #1;
        Dselect = 32'h00400000;
        Aselect = 32'h00400000;
        Bselect = 32'h00400000;
        dbus    = 32'hABCDEF90;
        wr_en   = 1'b1;
        #1;
`ifdef ONEHOT_REGFILE_BYPASS_EN
        byp_exp = 32'hABCDEF90;
`else
        byp_exp = 32'h0;
`endif
        chk("rdw_pre_a", abus, byp_exp);
        chk("rdw_pre_b", bbus, byp_exp);
        fall();
        wr_en = 1'b0;
        chk("rdw_post_a", abus, 32'hABCDEF90);
        chk("rdw_post_b", bbus, 32'hABCDEF90);

        // zero register is never forwarded
        @(posedge clk);
        #1;
        Dselect = 32'h00000001;
        Aselect = 32'h00000001;
        dbus    = 32'h00000005;
        wr_en   = 1'b1;
        #1;
        chk("zero_byp", abus, 32'h0);
        fall();
        wr_en = 1'b0;
        chk("zero_byp_post", abus, 32'h0);

        // async reset while clk is high
        wr(32'h00000040, 32'h80876263);
        Aselect = 32'h00000040;
        #1;
        chk("pre_arst", abus, 32'h80876263);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_clk", {31'b0, clk}, 32'h1);
        chk("arst_abus", abus, 32'h0);
        Aselect = 32'h00400000;
        #1;
        chk("arst_other", abus, 32'h0);
        fall();
        reset_n = 1'b1;
        fall();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
